// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word and cache-line types
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
endpackage

// File: rtl/ewb_cam_fifo.sv
// rtl/ewb_cam_fifo.sv - circular line FIFO with youngest-match address lookup
module ewb_cam_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  lc3b_word               addr_i,
  input  lc3b_c_line             wdata_i,
  input  logic                   push_i,
  input  logic                   coal_i,
  input  logic                   pop_i,
  input  logic                   excl_head_i,
  output logic                   rd_hit_o,
  output lc3b_c_line             rd_data_o,
  output logic                   wr_hit_o,
  output lc3b_word               head_addr_o,
  output lc3b_c_line             head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  lc3b_word         addr_q [DEPTH];
  lc3b_c_line       data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q, rd_idx, wr_idx, idx;
  logic [PW:0]      count_q;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    rd_hit_o = 1'b0;
    wr_hit_o = 1'b0;
    rd_idx   = '0;
    wr_idx   = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && addr_q[idx] == addr_i) begin
        rd_hit_o = 1'b1;
        rd_idx   = idx;
        if (!(excl_head_i && i == 0)) begin
          wr_hit_o = 1'b1;
          wr_idx   = idx;
        end
      end
    end
  end

  assign rd_data_o   = data_q[rd_idx];
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign count_o     = count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= wdata_i;
    end
    if (coal_i) data_q[wr_idx] <= wdata_i;
  end
endmodule

// File: rtl/multi_entry_ewb_l2.sv
// rtl/multi_entry_ewb_l2.sv - multi-entry eviction write buffer between L2 and physical memory
module multi_entry_ewb_l2
  import lc3b_types::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_THRESH = DEPTH / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ewb_mem_read,
  input  logic       ewb_mem_write,
  input  lc3b_word   ewb_mem_address,
  input  lc3b_c_line ewb_mem_wdata,
  output logic       ewb_mem_resp,
  output lc3b_c_line ewb_mem_rdata,
  input  logic       pmem_resp,
  input  lc3b_c_line pmem_rdata,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_c_line pmem_wdata
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;
  state_e state_q, state_d;

  logic [CW-1:0] count;
  logic          full, rd_hit, wr_hit, read_hit, read_miss, wr_req;
  logic          coal, push, blocked, pop;
  lc3b_c_line    rd_data, head_data;
  lc3b_word      head_addr;

  ewb_cam_fifo #(.DEPTH(DEPTH)) u_cam (
    .clk_i       (clk),
    .reset_i     (reset),
    .addr_i      (ewb_mem_address),
    .wdata_i     (ewb_mem_wdata),
    .push_i      (push),
    .coal_i      (coal),
    .pop_i       (pop),
    .excl_head_i (state_q == DRAIN),
    .rd_hit_o    (rd_hit),
    .rd_data_o   (rd_data),
    .wr_hit_o    (wr_hit),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count)
  );

  // Full comes from the registered count only, so a pop never frees space for a write in the same cycle.
  assign full      = (count == CW'(DEPTH));
  assign read_hit  = ewb_mem_read && rd_hit;
  assign read_miss = ewb_mem_read && !rd_hit;
  assign wr_req    = ewb_mem_write && !ewb_mem_read;
  assign coal      = wr_req && wr_hit;
  assign push      = wr_req && !wr_hit && !full;
  assign blocked   = wr_req && !wr_hit && full;
  assign pop       = (state_q == DRAIN) && pmem_resp;

  always_comb begin
    state_d       = state_q;
    ewb_mem_resp  = read_hit || coal || push;
    ewb_mem_rdata = read_hit ? rd_data : '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    pmem_wdata    = '0;
    unique case (state_q)
      FILL: begin
        pmem_read     = 1'b1;
        pmem_address  = ewb_mem_address;
        ewb_mem_resp  = pmem_resp || coal || push;
        ewb_mem_rdata = pmem_resp ? pmem_rdata : '0;
        if (pmem_resp) state_d = IDLE;
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = head_addr;
        pmem_wdata   = head_data;
        if (pmem_resp) state_d = IDLE;
      end
      default: begin
        if (read_miss) begin
          state_d = FILL;
        end else if (count != '0 && (count >= CW'(DRAIN_THRESH) ||
                     (!ewb_mem_read && !ewb_mem_write) || blocked)) begin
          state_d = DRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
endmodule

// File: tb/tb_multi_entry_ewb_l2.sv
// tb/tb_multi_entry_ewb_l2.sv - scoreboard bench for multi_entry_ewb_l2
module tb_multi_entry_ewb_l2;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset, ewb_mem_read, ewb_mem_write, ewb_mem_resp;
  lc3b_word   ewb_mem_address, pmem_address;
  lc3b_c_line ewb_mem_wdata, ewb_mem_rdata, pmem_rdata, pmem_wdata;
  logic       pmem_resp, pmem_read, pmem_write;

  int         errors = 0;
  int         checks = 0;
  bit         mem_en = 1'b0;
  lc3b_c_line exp_resp_q[$];
  lc3b_word   exp_wb_a[$];
  lc3b_c_line exp_wb_d[$];

  multi_entry_ewb_l2 #(.DEPTH(4), .DRAIN_THRESH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .ewb_mem_read    (ewb_mem_read),
    .ewb_mem_write   (ewb_mem_write),
    .ewb_mem_address (ewb_mem_address),
    .ewb_mem_wdata   (ewb_mem_wdata),
    .ewb_mem_resp    (ewb_mem_resp),
    .ewb_mem_rdata   (ewb_mem_rdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ewb_mem_resp pops one expected read-data value.
  initial forever begin
    @(negedge clk);
    #4;
    if (!reset) begin
      checks++;
      if ((pmem_read && pmem_write) || (!ewb_mem_resp && ewb_mem_rdata != '0)) begin
        errors++;
        $display("FAIL protocol: pmem_read=%0b pmem_write=%0b resp=%0b rdata=%h (need exclusive pmem, zero idle rdata)",
                 pmem_read, pmem_write, ewb_mem_resp, ewb_mem_rdata);
      end
      if (ewb_mem_resp) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h expected no response", ewb_mem_rdata);
        end else begin
          chk("resp_rdata", ewb_mem_rdata, exp_resp_q.pop_front());
        end
      end
    end
  end

  // Physical memory model: answers two cycles after a request; write-backs are scored in order.
  initial begin
    int lat;
    lc3b_word   a;
    lc3b_c_line d;
    lat = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        lat = 0;
      end else if (mem_en && !reset && (pmem_read || pmem_write)) begin
        lat++;
        if (lat >= 2) begin
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata = {8{pmem_address}};
          end else if (exp_wb_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got addr %h data %h expected none", pmem_address, pmem_wdata);
          end else begin
            a = exp_wb_a.pop_front();
            d = exp_wb_d.pop_front();
            chk("wb_addr", 128'(pmem_address), 128'(a));
            chk("wb_data", pmem_wdata, d);
          end
        end
      end else begin
        lat = 0;
      end
    end
  end

  // mode: 0 none, 1 resp same cycle without pmem_read, 2 read miss goes to pmem, 3 resp one cycle after pmem_resp
  task automatic drive(input bit rd, input lc3b_word a, input lc3b_c_line d,
                       input lc3b_c_line exp, input int mode, input string name);
    bit got, prev;
    got = 1'b0;
    prev = 1'b0;
    exp_resp_q.push_back(exp);
    ewb_mem_read = rd;
    ewb_mem_write = !rd;
    ewb_mem_address = a;
    ewb_mem_wdata = rd ? '0 : d;
    for (int n = 0; n < 200 && !got; n++) begin
      #4;
      if (mode == 1 && n == 0) begin
        checks++;
        if (!ewb_mem_resp || pmem_read) begin
          errors++;
          $display("FAIL %s_same_cycle: got resp=%0b pmem_read=%0b expected 1/0", name, ewb_mem_resp, pmem_read);
        end
      end
      if (mode == 2 && n == 1) begin
        checks++;
        if (!pmem_read || ewb_mem_resp) begin
          errors++;
          $display("FAIL %s_fill: got pmem_read=%0b resp=%0b expected 1/0", name, pmem_read, ewb_mem_resp);
        end
      end
      if (ewb_mem_resp) begin
        got = 1'b1;
        if (mode == 3) begin
          checks++;
          if (!prev) begin
            errors++;
            $display("FAIL %s_latency: got resp with prior pmem_resp=%0b expected 1", name, prev);
          end
        end
      end
      prev = pmem_resp;
      @(negedge clk);
    end
    ewb_mem_read = 1'b0;
    ewb_mem_write = 1'b0;
    ewb_mem_wdata = '0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no resp expected resp", name);
      if (exp_resp_q.size() != 0) void'(exp_resp_q.pop_back());
    end
  endtask

  task automatic check_count(input string name, input int exp);
    #4;
    chk(name, 128'(dut.u_cam.count_o), 128'(exp));
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      #4;
      done = (dut.u_cam.count_o == 0) && !pmem_write && !pmem_read;
    end
    chk({name, "_count"}, 128'(dut.u_cam.count_o), 128'(0));
    chk({name, "_wb_left"}, 128'(exp_wb_a.size()), 128'(0));
    @(negedge clk);
  endtask

  task automatic wait_pmem_write(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      #4;
      seen = pmem_write;
      @(negedge clk);
    end
    chk({name, "_drain_start"}, 128'(seen), 128'(1));
  endtask

  initial begin
    bit act;
    reset = 1'b1;
    ewb_mem_read = 1'b0;
    ewb_mem_write = 1'b0;
    ewb_mem_address = '0;
    ewb_mem_wdata = '0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_resp", 128'(ewb_mem_resp), 128'(0));
    chk("rst_pmem", 128'({pmem_read, pmem_write}), 128'(0));
    chk("rst_count", 128'(dut.u_cam.count_o), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    mem_en = 1'b1;

    // Three writes back to back, drained in order.
    exp_wb_a = '{16'h1000, 16'h1040, 16'h1080};
    exp_wb_d = '{{8{16'hAAAA}}, {8{16'hBBBB}}, {8{16'hCCCC}}};
    drive(0, 16'h1000, {8{16'hAAAA}}, '0, 1, "wr_a");
    drive(0, 16'h1040, {8{16'hBBBB}}, '0, 1, "wr_b");
    drive(0, 16'h1080, {8{16'hCCCC}}, '0, 1, "wr_c");
    wait_idle("order");

    // Coalesce into the same line.
    exp_wb_a.push_back(16'h2000);
    exp_wb_d.push_back({8{16'hD2D2}});
    drive(0, 16'h2000, {8{16'hD1D1}}, '0, 1, "wr_d1");
    drive(0, 16'h2000, {8{16'hD2D2}}, '0, 1, "wr_d2");
    check_count("coal_count", 1);
    wait_idle("coal");

    // Read hit from the buffer, then a miss through to pmem.
    exp_wb_a.push_back(16'h3000);
    exp_wb_d.push_back({8{16'h3F3F}});
    drive(0, 16'h3000, {8{16'h3F3F}}, '0, 1, "wr_f");
    drive(1, 16'h3000, '0, {8{16'h3F3F}}, 1, "rd_hit");
    drive(1, 16'h4000, '0, {8{16'h4000}}, 2, "rd_miss");
    wait_idle("hitmiss");

    // Full buffer blocks a fifth write until the head drains.
    mem_en = 1'b0;
    exp_wb_a = '{16'h5100, 16'h5140, 16'h5180, 16'h51C0, 16'h5000};
    exp_wb_d = '{{8{16'h5101}}, {8{16'h5141}}, {8{16'h5181}}, {8{16'h51C1}}, {8{16'h5001}}};
    drive(0, 16'h5100, {8{16'h5101}}, '0, 1, "wr_f1");
    drive(0, 16'h5140, {8{16'h5141}}, '0, 1, "wr_f2");
    drive(0, 16'h5180, {8{16'h5181}}, '0, 1, "wr_f3");
    drive(0, 16'h51C0, {8{16'h51C1}}, '0, 1, "wr_f4");
    check_count("full_count", 4);
    fork
      drive(0, 16'h5000, {8{16'h5001}}, '0, 3, "wr_blocked");
      begin
        repeat (4) @(negedge clk);
        mem_en = 1'b1;
      end
    join
    check_count("after_block_count", 4);
    wait_idle("full");

    // Write to the draining head pushes a new entry; the read sees the youngest.
    mem_en = 1'b0;
    exp_wb_a = '{16'h6000, 16'h6000};
    exp_wb_d = '{{8{16'h6D6D}}, {8{16'h6E6E}}};
    drive(0, 16'h6000, {8{16'h6D6D}}, '0, 1, "wr_hd");
    wait_pmem_write("head");
    drive(0, 16'h6000, {8{16'h6E6E}}, '0, 1, "wr_he");
    check_count("head_count", 2);
    drive(1, 16'h6000, '0, {8{16'h6E6E}}, 1, "rd_young");
    mem_en = 1'b1;
    wait_idle("head");

    // Reset during a drain discards everything.
    mem_en = 1'b0;
    drive(0, 16'h7000, {8{16'h7070}}, '0, 1, "wr_r1");
    drive(0, 16'h7040, {8{16'h7474}}, '0, 1, "wr_r2");
    drive(0, 16'h7080, {8{16'h7878}}, '0, 1, "wr_r3");
    wait_pmem_write("rst");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("rst_drain_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_drain_count", 128'(dut.u_cam.count_o), 128'(0));
    @(negedge clk);
    mem_en = 1'b1;
    act = 1'b0;
    repeat (10) begin
      #4;
      act = act | pmem_read | pmem_write;
      @(negedge clk);
    end
    chk("rst_no_activity", 128'(act), 128'(0));
    chk("resp_left", 128'(exp_resp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/multi_entry_ewb_l2.md
MULTI_ENTRY_EWB_L2 -- requirements
Module: multi_entry_ewb_l2

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered lines; SHALL be a power of 2 and at least 2.
REQ-002 Parameter DRAIN_THRESH, default DEPTH/2, occupancy at which draining SHALL start while requests are pending; range 1..DEPTH.
REQ-003 Port list SHALL be, in order:
- clk  in  1  clock; one clock, all state on its rising edge.
- reset  in  1  synchronous active-high reset.
- ewb_mem_read  in  1  L2 line read request.
- ewb_mem_write  in  1  L2 eviction (dirty line) write request.
- ewb_mem_address  in  lc3b_word  line address.
- ewb_mem_wdata  in  lc3b_c_line  evicted line data.
- ewb_mem_resp  out  1  request complete this cycle.
- ewb_mem_rdata  out  lc3b_c_line  read data, valid with resp on a read.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  lc3b_c_line  physical memory read data.
- pmem_read  out  1  physical memory read request.
- pmem_write  out  1  physical memory write request.
- pmem_address  out  lc3b_word  physical memory address.
- pmem_wdata  out  lc3b_c_line  physical memory write data.

Function
REQ-004 Entries SHALL form a circular FIFO (head, tail pointers wrapping modulo DEPTH; count 0..DEPTH); full = (count == DEPTH), computed from registered count only.
REQ-005 Controller states SHALL be IDLE, FILL (pmem read pass-through), DRAIN (head write-back outstanding).
REQ-006 Read hit (address equals any valid entry, including the draining head) SHALL assert ewb_mem_resp in the same cycle with that entry's data; on multiple matches the youngest entry SHALL win; a hit SHALL never touch pmem.
REQ-007 Read miss in IDLE SHALL enter FILL, and read priority SHALL hold over any drain condition; in FILL pmem_read=1, pmem_address=ewb_mem_address, ewb_mem_resp=pmem_resp, ewb_mem_rdata=pmem_rdata; return to IDLE on pmem_resp.
REQ-008 Read miss in DRAIN SHALL be stalled (no resp) until the write-back completes.
REQ-009 Write whose address matches a valid non-draining entry SHALL overwrite that entry's data (coalesce), resp same cycle, count unchanged.
REQ-010 Write that does not coalesce and buffer not full SHALL push at tail, resp same cycle, in any state.
REQ-011 Write with buffer full and no coalesce SHALL receive no resp until a later cycle where space exists; a pop and a blocked write in the same cycle SHALL NOT bypass.
REQ-012 IDLE SHALL enter DRAIN when count>0 and: no read miss pending and (count>=DRAIN_THRESH, or no request present, or a write is blocked by full).
REQ-013 In DRAIN pmem_write=1, pmem_address/pmem_wdata=head entry, held stable; head SHALL NOT be modified; on pmem_resp pop head and return to IDLE.
REQ-014 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-015 pmem_read and pmem_write SHALL never both be 1; outside FILL/DRAIN both SHALL be 0.
REQ-016 Outputs SHALL be combinational from state, entries and inputs; ewb_mem_rdata SHALL be 0 when not responding.

Reset
REQ-017 On reset: state IDLE, count 0, head=tail=0, all entry valid bits 0; all outputs 0 in the following cycle.
REQ-018 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the transaction and discard buffered lines; pmem_read/pmem_write drop the next cycle.

Structure
REQ-019 lc3b_word and lc3b_c_line SHALL come from lc3b_types; DEPTH/DRAIN_THRESH stay module parameters; the state enum is local.
REQ-020 Entry storage, valid bits and youngest-match address comparison SHALL be one sub-module, ewb_cam_fifo; controller stays in multi_entry_ewb_l2.

Verification
REQ-021 DEPTH=4: writes to 0x1000,0x1040,0x1080 (data A,B,C) each resp same cycle; then idle -> three pmem writes in order 0x1000,0x1040,0x1080, count back to 0.
REQ-022 Write 0x2000 data D1, then 0x2000 data D2 while not draining -> count 1, single pmem write of D2.
REQ-023 Buffer holds 0x3000; read 0x3000 -> resp same cycle with buffered data, pmem_read stays 0; read 0x4000 -> pmem_read until pmem_resp, rdata=pmem_rdata.
REQ-024 Fill to 4 entries, 5th write 0x5000 -> no resp until head pmem_resp and one cycle later; then accepted, count 4.
REQ-025 Head 0x6000 draining, write 0x6000 data E -> new entry pushed; read 0x6000 returns E; two pmem writes to 0x6000, last with E.
REQ-026 Assert reset during DRAIN with 3 entries -> next cycle pmem_write=0, count 0, no further pmem activity.
